// File: rtl/key_matrix_scanner_pkg.sv
// Shared types and constants for the 8x8 key matrix scanner.
package key_matrix_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } scanState_t;

  localparam int NUM_ROWS  = 8;
  localparam int NUM_COLS  = 8;
  localparam int NUM_KEYS  = 64;
  localparam int KEY_IDX_W = 6;

  typedef logic [KEY_IDX_W-1:0] keyIdx_t;

endpackage

// File: rtl/lowest_set_bit64.sv
// Combinational priority encoder: index of the lowest set bit of a 64-bit mask.
module lowest_set_bit64
  import key_matrix_scanner_pkg::*;
(
  input  logic [NUM_KEYS-1:0] mask,
  output keyIdx_t             idx,
  output logic                found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = KEY_IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_matrix_scanner.sv
// 8x8 key matrix scanner with frame debounce and per-key change events.
// Optional ghost-frame rejection: define KEYSCAN_GHOST_REJECT_EN.
module key_matrix_scanner
  import key_matrix_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scanTick,
  input  logic [NUM_ROWS-1:0] rowIn,
  output logic [NUM_COLS-1:0] colOut,
  output logic [NUM_KEYS-1:0] keyState,
  output logic                eventValid,
  output keyIdx_t             eventCode,
  output logic                eventPress
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  scanState_t          state;
  logic [2:0]          col;
  logic [2:0]          nextCol;
  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] prevRaw;
  logic [NUM_KEYS-1:0] frame;
  logic [NUM_KEYS-1:0] pending;
  logic [3:0]          cnt;
  logic                ghost;
  logic                commitDue;
  keyIdx_t             lsbIdx;
  logic                lsbFound;

  assign nextCol = col + 3'd1;

  // Raw frame as it will look once the current column is latched.
  always_comb begin
    frame = raw;
    frame[{col, 3'b000} +: NUM_ROWS] = rowIn;
  end

`ifdef KEYSCAN_GHOST_REJECT_EN
  function automatic logic hasGhost(input logic [NUM_KEYS-1:0] f);
    logic [NUM_ROWS-1:0] t;
    hasGhost = 1'b0;
    for (int i = 0; i < NUM_COLS - 1; i++) begin
      for (int j = i + 1; j < NUM_COLS; j++) begin
        t = f[i*NUM_ROWS +: NUM_ROWS] & f[j*NUM_ROWS +: NUM_ROWS];
        if ((t & (t - 8'd1)) != '0) hasGhost = 1'b1;
      end
    end
  endfunction

  assign ghost = hasGhost(frame);
`else
  assign ghost = 1'b0;
`endif

  // A commit waits until every event of the previous one is delivered.
  assign commitDue = (state != IDLE) && (cnt == DEB) &&
                     (prevRaw != keyState) && (pending == '0);

  lowest_set_bit64 uLsb (
    .mask  (pending),
    .idx   (lsbIdx),
    .found (lsbFound)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      col        <= '0;
      colOut     <= '0;
      keyState   <= '0;
      raw        <= '0;
      prevRaw    <= '0;
      cnt        <= '0;
      pending    <= '0;
      eventValid <= 1'b0;
      eventCode  <= '0;
      eventPress <= 1'b0;
    end else begin
      eventValid <= 1'b0;
      if (state == IDLE) begin
        if (scanTick) begin
          state  <= SCAN;
          col    <= '0;
          colOut <= 8'h01;
        end
      end else begin
        if (scanTick) begin
          raw    <= frame;
          col    <= nextCol;
          colOut <= 8'h01 << nextCol;
          if (col == 3'd7) begin
            prevRaw <= frame;
            if (ghost)
              cnt <= '0;
            else if (frame == prevRaw)
              cnt <= (cnt >= DEB) ? DEB : cnt + 4'd1;
            else
              cnt <= 4'd1;
          end
        end
        if (commitDue) begin
          pending  <= keyState ^ prevRaw;
          keyState <= prevRaw;
          state    <= EMIT;
        end else if (state == EMIT) begin
          if (lsbFound) begin
            eventValid      <= 1'b1;
            eventCode       <= lsbIdx;
            eventPress      <= keyState[lsbIdx];
            pending[lsbIdx] <= 1'b0;
          end else begin
            state <= SCAN;
          end
        end
      end
    end
  end

endmodule
